// File: rtl/pipe_stage_reg.sv
// DEPTH-deep pipeline register chain with global stall, flush-to-NOP and deferred flush.
// Optional performance counters are enabled by defining PIPE_STAGE_PERF_EN.
module pipe_stage_reg #(
    parameter int                DATA_W    = 32,
    parameter int                PC_W      = 32,
    parameter int                DEPTH     = 1,
    parameter logic [DATA_W-1:0] NOP_VALUE = '0
) (
    input  logic              Clock,
    input  logic              Reset_n,
    input  logic              Valid_In,
    input  logic [DATA_W-1:0] Data_In,
    input  logic [PC_W-1:0]   PCPlusFour_In,
    input  logic              Flush,
    input  logic              Stall,
    output logic              Valid_Out,
    output logic [DATA_W-1:0] Data_Out,
    output logic [PC_W-1:0]   PCPlusFour_Out,
    output logic              Flush_Pending
`ifdef PIPE_STAGE_PERF_EN
    ,
    output logic [15:0]       Stall_Count,
    output logic [15:0]       Flush_Count
`endif
);

    generate
        if (DEPTH < 1 || DEPTH > 4) begin : g_depth_check
            $error("pipe_stage_reg: DEPTH must be in 1..4");
        end
    endgenerate

    typedef enum logic {
        RUN  = 1'b0,
        PEND = 1'b1
    } pend_state_t;

    typedef enum logic [1:0] {
        OP_HOLD   = 2'd0,
        OP_SQUASH = 2'd1,
        OP_SHIFT  = 2'd2
    } stage_op_t;

    pend_state_t       state;
    pend_state_t       next_state;
    stage_op_t         stage_op;

    logic              valid_q [DEPTH];
    logic [DATA_W-1:0] data_q  [DEPTH];
    logic [PC_W-1:0]   pc_q    [DEPTH];

    logic [DATA_W-1:0] in_data;
    logic [PC_W-1:0]   in_pc;

    always_ff @(posedge Clock or negedge Reset_n) begin
        if (!Reset_n) begin
            state <= RUN;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            RUN:     if (Stall && Flush) next_state = PEND;
            PEND:    if (!Stall)         next_state = RUN;
            default: next_state = RUN;
        endcase
    end

    // Stall outranks flush; a latched flush is applied on the first unstalled edge.
    always_comb begin
        stage_op = OP_SHIFT;
        if (Stall) begin
            stage_op = OP_HOLD;
        end else if (Flush || state == PEND) begin
            stage_op = OP_SQUASH;
        end
        Flush_Pending = (state == PEND);
    end

    // Invalid input entries are normalised so a bubble always carries NOP/zero.
    always_comb begin
        in_data = Valid_In ? Data_In : NOP_VALUE;
        in_pc   = Valid_In ? PCPlusFour_In : '0;
    end

    always_ff @(posedge Clock or negedge Reset_n) begin
        if (!Reset_n) begin
            for (int k = 0; k < DEPTH; k++) begin
                valid_q[k] <= 1'b0;
                data_q[k]  <= NOP_VALUE;
                pc_q[k]    <= '0;
            end
        end else begin
            case (stage_op)
                OP_SQUASH: begin
                    for (int k = 0; k < DEPTH; k++) begin
                        valid_q[k] <= 1'b0;
                        data_q[k]  <= NOP_VALUE;
                        pc_q[k]    <= '0;
                    end
                end
                OP_SHIFT: begin
                    valid_q[0] <= Valid_In;
                    data_q[0]  <= in_data;
                    pc_q[0]    <= in_pc;
                    for (int k = 1; k < DEPTH; k++) begin
                        valid_q[k] <= valid_q[k-1];
                        data_q[k]  <= data_q[k-1];
                        pc_q[k]    <= pc_q[k-1];
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign Valid_Out      = valid_q[DEPTH-1];
    assign Data_Out       = data_q[DEPTH-1];
    assign PCPlusFour_Out = pc_q[DEPTH-1];

`ifdef PIPE_STAGE_PERF_EN
    // Saturating event counters; a deferred flush counts once, when applied.
    always_ff @(posedge Clock or negedge Reset_n) begin
        if (!Reset_n) begin
            Stall_Count <= '0;
            Flush_Count <= '0;
        end else begin
            if (Stall && Stall_Count != 16'hFFFF) begin
                Stall_Count <= Stall_Count + 16'd1;
            end
            if (stage_op == OP_SQUASH && Flush_Count != 16'hFFFF) begin
                Flush_Count <= Flush_Count + 16'd1;
            end
        end
    end
`endif

endmodule
